// File: rtl/controlador_sessao_perfil.sv
// Session controller with per-profile access control: login/lockout FSM,
// idle-timeout supervision and registered grant/deny decisions for protected operations.
module controlador_sessao_perfil #(
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned MAX_FALHAS = 3,
   parameter int unsigned T_BLOQUEIO = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] perfil,
   input  logic       login,
   input  logic       senha_ok,
   input  logic       logout,
   input  logic       atividade,
   input  logic       op_req,
   input  logic [1:0] nivel_req,
   output logic       sessao_ativa,
   output logic [1:0] perfil_ativo,
   output logic       op_grant,
   output logic       op_deny,
   output logic       bloqueado,
   output logic [1:0] falhas,
   output logic       timeout,
   output logic [1:0] estado_dbg
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ATIVA    = 2'b01,
      BLOQUEIO = 2'b10
   } estado_t;

   localparam logic [7:0] TIMER_LIM  = 8'(TIMEOUT - 1);
   localparam logic [7:0] LOCK_INI   = 8'(T_BLOQUEIO - 1);
   localparam logic [1:0] FALHAS_LIM = 2'(MAX_FALHAS);

   estado_t    estado, estado_nxt;
   logic [7:0] timer, timer_nxt;
   logic [7:0] lock_cnt, lock_nxt;
   logic [1:0] perfil_nxt;
   logic [1:0] falhas_nxt;
   logic [1:0] falhas_inc;
   logic       grant_nxt;
   logic       deny_nxt;
   logic       timeout_nxt;
   logic       login_aceito;

   assign estado_dbg   = estado;
   assign falhas_inc   = falhas + 2'd1;
   // GUEST sessions are open: the password flag is irrelevant for profile 00.
   assign login_aceito = senha_ok || (perfil == 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         estado       <= IDLE;
         timer        <= 8'd0;
         lock_cnt     <= 8'd0;
         perfil_ativo <= 2'b00;
         falhas       <= 2'b00;
         op_grant     <= 1'b0;
         op_deny      <= 1'b0;
         timeout      <= 1'b0;
         sessao_ativa <= 1'b0;
         bloqueado    <= 1'b0;
      end else begin
         estado       <= estado_nxt;
         timer        <= timer_nxt;
         lock_cnt     <= lock_nxt;
         perfil_ativo <= perfil_nxt;
         falhas       <= falhas_nxt;
         op_grant     <= grant_nxt;
         op_deny      <= deny_nxt;
         timeout      <= timeout_nxt;
         sessao_ativa <= (estado_nxt == ATIVA);
         bloqueado    <= (estado_nxt == BLOQUEIO);
      end
   end

   always_comb begin
      estado_nxt  = estado;
      timer_nxt   = timer;
      lock_nxt    = lock_cnt;
      perfil_nxt  = perfil_ativo;
      falhas_nxt  = falhas;
      grant_nxt   = 1'b0;
      deny_nxt    = 1'b0;
      timeout_nxt = 1'b0;

      case (estado)
         IDLE: begin
            deny_nxt = op_req;
            if (login) begin
               if (login_aceito) begin
                  estado_nxt = ATIVA;
                  perfil_nxt = perfil;
                  falhas_nxt = 2'b00;
                  timer_nxt  = 8'd0;
               end else if (falhas_inc == FALHAS_LIM) begin
                  estado_nxt = BLOQUEIO;
                  lock_nxt   = LOCK_INI;
                  falhas_nxt = 2'b00;
               end else begin
                  falhas_nxt = falhas_inc;
               end
            end
         end

         ATIVA: begin
            // Logout outranks both a pending operation and an expiring timer.
            if (logout) begin
               estado_nxt = IDLE;
               perfil_nxt = 2'b00;
               timer_nxt  = 8'd0;
               deny_nxt   = op_req;
            end else if (op_req) begin
               timer_nxt = 8'd0;
               if (perfil_ativo >= nivel_req) begin
                  grant_nxt = 1'b1;
               end else begin
                  deny_nxt = 1'b1;
               end
            end else if (atividade) begin
               timer_nxt = 8'd0;
            end else if (timer == TIMER_LIM) begin
               estado_nxt  = IDLE;
               perfil_nxt  = 2'b00;
               timer_nxt   = 8'd0;
               timeout_nxt = 1'b1;
            end else begin
               timer_nxt = timer + 8'd1;
            end
         end

         BLOQUEIO: begin
            deny_nxt = op_req;
            if (lock_cnt == 8'd0) begin
               estado_nxt = IDLE;
            end else begin
               lock_nxt = lock_cnt - 8'd1;
            end
         end

         default: begin
            estado_nxt = IDLE;
            perfil_nxt = 2'b00;
            falhas_nxt = 2'b00;
            timer_nxt  = 8'd0;
            lock_nxt   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_controlador_sessao_perfil.sv
// Bench for controlador_sessao_perfil: directed scenarios followed by random
// traffic, every output compared each cycle with a behavioural session model.
module tb_controlador_sessao_perfil;

   localparam int TMO  = 16;
   localparam int MAXF = 3;
   localparam int TBLQ = 32;

   localparam int M_IDLE = 0;
   localparam int M_SESS = 1;
   localparam int M_LOCK = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] perfil;
   logic       login;
   logic       senha_ok;
   logic       logout;
   logic       atividade;
   logic       op_req;
   logic [1:0] nivel_req;
   logic       sessao_ativa;
   logic [1:0] perfil_ativo;
   logic       op_grant;
   logic       op_deny;
   logic       bloqueado;
   logic [1:0] falhas;
   logic       timeout;
   logic [1:0] estado_dbg;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: session mode, latched profile, consecutive failures,
   // length of the current quiet run and cycles of lockout still to serve.
   int   m_mode = M_IDLE;
   int   m_prof = 0;
   int   m_fail = 0;
   int   m_quiet = 0;
   int   m_lock_left = 0;
   logic e_grant, e_deny, e_tmo;

   controlador_sessao_perfil #(
      .TIMEOUT   (TMO),
      .MAX_FALHAS(MAXF),
      .T_BLOQUEIO(TBLQ)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .perfil      (perfil),
      .login       (login),
      .senha_ok    (senha_ok),
      .logout      (logout),
      .atividade   (atividade),
      .op_req      (op_req),
      .nivel_req   (nivel_req),
      .sessao_ativa(sessao_ativa),
      .perfil_ativo(perfil_ativo),
      .op_grant    (op_grant),
      .op_deny     (op_deny),
      .bloqueado   (bloqueado),
      .falhas      (falhas),
      .timeout     (timeout),
      .estado_dbg  (estado_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic l, input logic s, input logic [1:0] p,
                        input logic lo, input logic a, input logic o, input logic [1:0] n);
      reset = 1'b0; login = l; senha_ok = s; perfil = p;
      logout = lo; atividade = a; op_req = o; nivel_req = n;
   endtask

   task automatic quiet();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   // Applies the session rules to the inputs present before the coming edge.
   task automatic model_step();
      e_grant = 1'b0; e_deny = 1'b0; e_tmo = 1'b0;
      if (reset) begin
         m_mode = M_IDLE; m_prof = 0; m_fail = 0; m_quiet = 0; m_lock_left = 0;
         return;
      end
      if (m_mode == M_IDLE) begin
         e_deny = op_req;
         if (login && (senha_ok || perfil == 2'b00)) begin
            m_mode = M_SESS; m_prof = int'(perfil); m_fail = 0; m_quiet = 0;
         end else if (login) begin
            m_fail = m_fail + 1;
            if (m_fail == MAXF) begin
               m_mode = M_LOCK; m_lock_left = TBLQ; m_fail = 0;
            end
         end
      end else if (m_mode == M_SESS) begin
         if (logout) begin
            m_mode = M_IDLE; e_deny = op_req;
         end else if (op_req) begin
            m_quiet = 0;
            if (m_prof >= int'(nivel_req)) e_grant = 1'b1;
            else e_deny = 1'b1;
         end else if (atividade) begin
            m_quiet = 0;
         end else begin
            m_quiet = m_quiet + 1;
            if (m_quiet == TMO) begin
               m_mode = M_IDLE; e_tmo = 1'b1;
            end
         end
      end else begin
         e_deny = op_req;
         m_lock_left = m_lock_left - 1;
         if (m_lock_left == 0) m_mode = M_IDLE;
      end
   endtask

   task automatic cycle();
      logic [1:0] e_prof;
      model_step();
      @(posedge clk);
      #1;
      e_prof = (m_mode == M_SESS) ? 2'(m_prof) : 2'b00;
      chk("sessao_ativa", 8'(sessao_ativa), 8'(m_mode == M_SESS));
      chk("perfil_ativo", 8'(perfil_ativo), 8'(e_prof));
      chk("op_grant",     8'(op_grant), 8'(e_grant));
      chk("op_deny",      8'(op_deny), 8'(e_deny));
      chk("bloqueado",    8'(bloqueado), 8'(m_mode == M_LOCK));
      chk("falhas",       8'(falhas), 8'(m_fail));
      chk("timeout",      8'(timeout), 8'(e_tmo));
      chk("grant_deny_excl", 8'(op_grant & op_deny), 8'd0);
   endtask

   task automatic do_reset();
      quiet();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic fail_login();
      drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
      cycle();
   endtask

   initial begin
      quiet();
      reset = 1'b1;
      repeat (2) cycle();
      chk("reset_sessao", 8'(sessao_ativa), 8'd0);
      chk("reset_falhas", 8'(falhas), 8'd0);

      // Tester login, then privilege checks above and below its level.
      drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00); cycle();
      chk("tester_login", 8'(perfil_ativo), 8'h2);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11); cycle();
      chk("tester_deny_adm", 8'(op_deny), 8'd1);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01); cycle();
      chk("tester_grant_user", 8'(op_grant), 8'd1);
      drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cycle();
      chk("logout_idle", 8'(sessao_ativa), 8'd0);

      // Three bad passwords lock the block; a good login inside the lock is ignored.
      fail_login(); chk("falha_1", 8'(falhas), 8'd1);
      fail_login(); chk("falha_2", 8'(falhas), 8'd2);
      fail_login();
      chk("lock_enter", 8'(bloqueado), 8'd1);
      chk("lock_falhas_clr", 8'(falhas), 8'd0);
      drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (TBLQ - 1) cycle();
      chk("lock_last_cycle", 8'(bloqueado), 8'd1);
      cycle();
      chk("lock_release", 8'(bloqueado), 8'd0);
      chk("lock_login_ignored", 8'(sessao_ativa), 8'd0);
      quiet(); cycle();

      // Guest needs no password and only reaches level-00 resources.
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00); cycle();
      chk("guest_login", 8'(sessao_ativa), 8'd1);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00); cycle();
      chk("guest_grant", 8'(op_grant), 8'd1);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01); cycle();
      chk("guest_deny", 8'(op_deny), 8'd1);

      // Inactivity: the sixteenth quiet cycle ends the session.
      quiet();
      repeat (TMO - 1) cycle();
      chk("tmo_not_yet", 8'(timeout), 8'd0);
      cycle();
      chk("tmo_fire", 8'(timeout), 8'd1);
      chk("tmo_sessao", 8'(sessao_ativa), 8'd0);
      cycle();
      chk("tmo_pulse_end", 8'(timeout), 8'd0);

      // Activity every ten cycles keeps the session alive.
      drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00); cycle();
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 1'b0, 2'b00, 1'b0, (i % 10) == 9, 1'b0, 2'b00);
         cycle();
      end
      chk("activity_alive", 8'(sessao_ativa), 8'd1);

      // Logout together with an operation request.
      drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00); cycle();
      chk("logout_op_deny", 8'(op_deny), 8'd1);
      chk("logout_op_grant", 8'(op_grant), 8'd0);

      // Logout on the cycle the timer would expire.
      drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00); cycle();
      quiet();
      repeat (TMO - 1) cycle();
      drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cycle();
      chk("logout_vs_tmo", 8'(timeout), 8'd0);

      // Reset in the middle of a lockout and of a session.
      fail_login(); fail_login(); fail_login();
      quiet(); repeat (5) cycle();
      do_reset();
      chk("rst_mid_lock", 8'(bloqueado), 8'd0);
      drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00); cycle();
      chk("login_after_rst", 8'(perfil_ativo), 8'h3);
      quiet(); repeat (3) cycle();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
      reset = 1'b1;
      cycle();
      chk("rst_mid_sess", 8'(sessao_ativa), 8'd0);
      chk("rst_over_op", 8'(op_grant), 8'd0);
      drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00); cycle();
      chk("login_after_rst2", 8'(sessao_ativa), 8'd1);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
               $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)));
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
